// File: rtl/ycr1_cache_defs.sv
// Shared icache definitions: tag entry layout and the tag-side FSM state encoding.
package ycr1_cache_defs;

    localparam int unsigned TAG_W = 20;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
    } type_icache_tag_mem_s;

    typedef enum logic [2:0] {
        StIdle,
        StHitRd,
        StHitAck,
        StMissWait,
        StPreWait
    } icache_tag_state_e;

endpackage

// File: rtl/icache_tag_fsm_if.sv
// CPU-side Wishbone-style request bus of the icache front end.
interface icache_tag_fsm_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) ();
    logic          stb;
    logic [AW-1:0] adr;
    logic          we;
    logic [DW-1:0] dat;
    logic          ack;
    logic          err;

    modport master (output stb, adr, we, input dat, ack, err);
    modport slave  (input stb, adr, we, output dat, ack, err);
endinterface

// File: rtl/icache_tag_cam.sv
// Fully-associative tag array: parallel compare, lowest-index hit, round-robin fill pointer.
module icache_tag_cam
    import ycr1_cache_defs::*;
#(
    parameter int unsigned Depth = 16
) (
    input  logic                       mclk,
    input  logic                       rst_n,
    input  logic [TAG_W-1:0]           lookup_tag_i,
    output logic                       hit_o,
    output logic [$clog2(Depth)-1:0]   hit_idx_o,
    input  logic                       tag_wr_i,
    input  logic                       tag_uwr_i,
    input  logic [$clog2(Depth)-1:0]   tag_uptr_i,
    input  type_icache_tag_mem_s       tag_wdata_i,
    output logic [$clog2(Depth)-1:0]   cur_loc_o
);
    localparam int unsigned IdxW = $clog2(Depth);

    type_icache_tag_mem_s tag_q [Depth];
    type_icache_tag_mem_s tag_d [Depth];
    logic [IdxW-1:0]      cur_loc_q, cur_loc_d;
    logic [Depth-1:0]     hit_vec;

    // tag_wr owns the cycle; a coincident tag_uwr is dropped.
    always_comb begin
        for (int i = 0; i < Depth; i++) begin
            tag_d[i] = tag_q[i];
        end
        cur_loc_d = cur_loc_q;
        if (tag_wr_i) begin
            tag_d[cur_loc_q] = tag_wdata_i;
            cur_loc_d = (cur_loc_q == IdxW'(Depth - 1)) ? '0 : cur_loc_q + IdxW'(1);
        end else if (tag_uwr_i) begin
            tag_d[tag_uptr_i] = tag_wdata_i;
        end
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < Depth; i++) begin
                tag_q[i] <= '0;
            end
            cur_loc_q <= '0;
        end else begin
            for (int i = 0; i < Depth; i++) begin
                tag_q[i] <= tag_d[i];
            end
            cur_loc_q <= cur_loc_d;
        end
    end

    always_comb begin
        hit_vec = '0;
        for (int i = 0; i < Depth; i++) begin
            hit_vec[i] = tag_q[i].valid && (tag_q[i].tag == lookup_tag_i);
        end
    end

    // Scan downwards so the lowest matching entry wins.
    always_comb begin
        hit_idx_o = '0;
        for (int i = Depth - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                hit_idx_o = IdxW'(i);
            end
        end
    end

    assign hit_o     = |hit_vec;
    assign cur_loc_o = cur_loc_q;

endmodule

// File: rtl/icache_tag_fsm.sv
// icache CPU front end: tag lookup, hit reads from SRAM port 1, miss/prefill hand-off to refill FSM.
module icache_tag_fsm
    import ycr1_cache_defs::*;
#(
    parameter int unsigned WB_AW      = 32,
    parameter int unsigned WB_DW      = 32,
    parameter int unsigned TAG_MEM_DP = 16,
    parameter int unsigned CACHESIZE  = 32
) (
    input  logic                                   mclk,
    input  logic                                   rst_n,
    icache_tag_fsm_if.slave                        wb_cpu,
    output logic [WB_AW-1:0]                       refill_adr_o,
    input  logic [WB_DW-1:0]                       refill_dat_i,
    input  logic                                   refill_ack_i,
    output logic                                   cache_refill_req,
    output logic                                   cache_prefill_req,
    input  logic                                   cache_busy,
    input  logic                                   cfg_prefill_en,
    input  logic                                   tag_wr,
    input  logic                                   tag_uwr,
    input  logic [$clog2(TAG_MEM_DP)-1:0]          tag_uptr,
    input  type_icache_tag_mem_s                   tag_wdata,
    output logic [$clog2(TAG_MEM_DP)-1:0]          tag_cur_loc,
    output logic                                   cache_mem_clk1,
    output logic                                   cache_mem_csb1,
    output logic [$clog2(TAG_MEM_DP)+$clog2(CACHESIZE)-1:0] cache_mem_addr1,
    input  logic [WB_DW-1:0]                       cache_mem_dout1
);
    localparam int unsigned IdxW   = $clog2(TAG_MEM_DP);
    localparam int unsigned WordW  = $clog2(CACHESIZE);
    localparam int unsigned TagLsb = WordW + 2;
    localparam int unsigned MemAw  = IdxW + WordW;

    icache_tag_state_e state_q, state_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic [WB_DW-1:0]  dat_q, dat_d;
    logic [WB_AW-1:0]  refill_adr_q, refill_adr_d;
    logic              refill_req_q, refill_req_d;
    logic              prefill_req_q, prefill_req_d;
    logic              csb1_q, csb1_d;
    logic [MemAw-1:0]  addr1_q, addr1_d;
    logic              seen_busy_q, seen_busy_d;
    logic              prefill_pend_q, prefill_pend_d;
    logic              prefill_en_q;
    logic              prefill_rise;

    logic              hit;
    logic [IdxW-1:0]   hit_idx;
    logic [TAG_W-1:0]  lookup_tag;
    logic              unused_adr;

    assign lookup_tag = wb_cpu.adr[TagLsb+TAG_W-1:TagLsb];
    assign unused_adr = ^{wb_cpu.adr[WB_AW-1:TagLsb+TAG_W], wb_cpu.adr[1:0]};

    icache_tag_cam #(
        .Depth (TAG_MEM_DP)
    ) u_tag_cam (
        .mclk         (mclk),
        .rst_n        (rst_n),
        .lookup_tag_i (lookup_tag),
        .hit_o        (hit),
        .hit_idx_o    (hit_idx),
        .tag_wr_i     (tag_wr),
        .tag_uwr_i    (tag_uwr),
        .tag_uptr_i   (tag_uptr),
        .tag_wdata_i  (tag_wdata),
        .cur_loc_o    (tag_cur_loc)
    );

    // prefill_en_q resets low, so a level already high at reset exit counts as an edge.
    assign prefill_rise = cfg_prefill_en & ~prefill_en_q;

    always_comb begin
        state_d        = state_q;
        ack_d          = 1'b0;
        err_d          = 1'b0;
        dat_d          = dat_q;
        refill_adr_d   = refill_adr_q;
        refill_req_d   = 1'b0;
        prefill_req_d  = 1'b0;
        csb1_d         = 1'b1;
        addr1_d        = addr1_q;
        seen_busy_d    = seen_busy_q;
        prefill_pend_d = prefill_pend_q | prefill_rise;

        unique case (state_q)
            StIdle: begin
                seen_busy_d = 1'b0;
                if (prefill_pend_q) begin
                    prefill_req_d  = 1'b1;
                    prefill_pend_d = prefill_rise;
                    state_d        = StPreWait;
                end else if (wb_cpu.stb && !ack_q && !err_q && !cache_busy) begin
                    if (wb_cpu.we) begin
                        err_d = 1'b1;
                        dat_d = '0;
                    end else if (hit) begin
                        csb1_d  = 1'b0;
                        addr1_d = {hit_idx, wb_cpu.adr[WordW+1:2]};
                        state_d = StHitRd;
                    end else begin
                        refill_adr_d = wb_cpu.adr;
                        refill_req_d = 1'b1;
                        state_d      = StMissWait;
                    end
                end
            end
            StHitRd: begin
                state_d = StHitAck;
            end
            StHitAck: begin
                ack_d   = 1'b1;
                dat_d   = cache_mem_dout1;
                state_d = StIdle;
            end
            StMissWait, StPreWait: begin
                // Only leave once the refill FSM has actually started and then finished.
                if (cache_busy) begin
                    seen_busy_d = 1'b1;
                end else if (seen_busy_q) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            ack_q          <= 1'b0;
            err_q          <= 1'b0;
            dat_q          <= '0;
            refill_adr_q   <= '0;
            refill_req_q   <= 1'b0;
            prefill_req_q  <= 1'b0;
            csb1_q         <= 1'b1;
            addr1_q        <= '0;
            seen_busy_q    <= 1'b0;
            prefill_pend_q <= 1'b0;
            prefill_en_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            ack_q          <= ack_d;
            err_q          <= err_d;
            dat_q          <= dat_d;
            refill_adr_q   <= refill_adr_d;
            refill_req_q   <= refill_req_d;
            prefill_req_q  <= prefill_req_d;
            csb1_q         <= csb1_d;
            addr1_q        <= addr1_d;
            seen_busy_q    <= seen_busy_d;
            prefill_pend_q <= prefill_pend_d;
            prefill_en_q   <= cfg_prefill_en;
        end
    end

    // During a miss the refill FSM answers the CPU directly.
    assign wb_cpu.ack        = (state_q == StMissWait) ? refill_ack_i : ack_q;
    assign wb_cpu.dat        = (state_q == StMissWait) ? refill_dat_i : dat_q;
    assign wb_cpu.err        = err_q;
    assign refill_adr_o      = refill_adr_q;
    assign cache_refill_req  = refill_req_q;
    assign cache_prefill_req = prefill_req_q;
    assign cache_mem_clk1    = mclk;
    assign cache_mem_csb1    = csb1_q;
    assign cache_mem_addr1   = addr1_q;

endmodule

// File: tb/tb_icache_tag_fsm.sv
// Directed bench for icache_tag_fsm: prefill, hits, misses, pointer wrap, write error, reset mid-refill.
module tb_icache_tag_fsm;
    import ycr1_cache_defs::*;

    logic                 mclk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [31:0]          refill_adr;
    logic [31:0]          refill_dat;
    logic                 refill_ack;
    logic                 cache_refill_req;
    logic                 cache_prefill_req;
    logic                 cache_busy;
    logic                 cfg_prefill_en;
    logic                 tag_wr;
    logic                 tag_uwr;
    logic [3:0]           tag_uptr;
    type_icache_tag_mem_s tag_wdata;
    logic [3:0]           tag_cur_loc;
    logic                 cache_mem_clk1;
    logic                 cache_mem_csb1;
    logic [8:0]           cache_mem_addr1;
    logic [31:0]          cache_mem_dout1 = '0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 mclk = ~mclk;

    icache_tag_fsm_if #(.AW(32), .DW(32)) wb_cpu ();

    icache_tag_fsm dut (
        .mclk              (mclk),
        .rst_n             (rst_n),
        .wb_cpu            (wb_cpu.slave),
        .refill_adr_o      (refill_adr),
        .refill_dat_i      (refill_dat),
        .refill_ack_i      (refill_ack),
        .cache_refill_req  (cache_refill_req),
        .cache_prefill_req (cache_prefill_req),
        .cache_busy        (cache_busy),
        .cfg_prefill_en    (cfg_prefill_en),
        .tag_wr            (tag_wr),
        .tag_uwr           (tag_uwr),
        .tag_uptr          (tag_uptr),
        .tag_wdata         (tag_wdata),
        .tag_cur_loc       (tag_cur_loc),
        .cache_mem_clk1    (cache_mem_clk1),
        .cache_mem_csb1    (cache_mem_csb1),
        .cache_mem_addr1   (cache_mem_addr1),
        .cache_mem_dout1   (cache_mem_dout1)
    );

    function automatic logic [31:0] sram_word(input logic [8:0] a);
        return 32'hC0DE_0000 | {23'h0, a};
    endfunction

    // SRAM port 1: one-cycle read latency after CS# sampled low.
    always @(posedge mclk) begin
        if (!cache_mem_csb1) cache_mem_dout1 <= sram_word(cache_mem_addr1);
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    task automatic count_prefill(output int n);
        n = 0;
        repeat (8) begin
            @(negedge mclk);
            if (cache_prefill_req) n++;
        end
    endtask

    task automatic cpu_hit(input string name, input logic [31:0] adr, input logic [8:0] exp_addr);
        logic got_ack, saw_csb, saw_req;
        logic [8:0] a_seen;
        logic [31:0] d;
        int lat;
        got_ack = 0; saw_csb = 0; saw_req = 0; a_seen = '0; d = '0; lat = -1;
        wb_cpu.stb = 1; wb_cpu.adr = adr; wb_cpu.we = 0;
        for (int i = 0; i < 10 && !got_ack; i++) begin
            @(negedge mclk);
            if (!cache_mem_csb1 && !saw_csb) begin saw_csb = 1; a_seen = cache_mem_addr1; end
            if (cache_refill_req) saw_req = 1;
            if (wb_cpu.ack) begin got_ack = 1; lat = i; d = wb_cpu.dat; end
        end
        tick();
        wb_cpu.stb = 0;
        check_eq({name, "_ack"}, 32'(got_ack), 32'd1);
        check_eq({name, "_lat"}, 32'(lat), 32'd3);
        check_eq({name, "_addr1"}, 32'(a_seen), 32'(exp_addr));
        check_eq({name, "_dat"}, d, sram_word(exp_addr));
        check_eq({name, "_noreq"}, 32'(saw_req), 32'd0);
        @(negedge mclk);
        check_eq({name, "_ackpulse"}, 32'(wb_cpu.ack), 32'd0);
        tick();
    endtask

    // Plays the refill FSM: busy, one CPU ack with data, one tag_wr of the new line.
    task automatic cpu_miss(input string name, input logic [31:0] adr, input logic [3:0] exp_loc,
                            input logic [31:0] rdat);
        logic seen;
        logic [31:0] radr;
        seen = 0; radr = '0;
        wb_cpu.stb = 1; wb_cpu.adr = adr; wb_cpu.we = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge mclk);
            if (cache_refill_req) begin seen = 1; radr = refill_adr; end
        end
        check_eq({name, "_req"}, 32'(seen), 32'd1);
        check_eq({name, "_radr"}, radr, adr);
        tick();
        cache_busy = 1;
        @(negedge mclk);
        check_eq({name, "_reqpulse"}, 32'(cache_refill_req), 32'd0);
        check_eq({name, "_noack"}, 32'(wb_cpu.ack), 32'd0);
        tick();
        refill_dat = rdat; refill_ack = 1;
        @(negedge mclk);
        check_eq({name, "_passack"}, 32'(wb_cpu.ack), 32'd1);
        check_eq({name, "_passdat"}, wb_cpu.dat, rdat);
        tick();
        refill_ack = 0; refill_dat = '0; wb_cpu.stb = 0;
        tag_wdata.valid = 1'b1; tag_wdata.tag = adr[26:7]; tag_wr = 1;
        tick();
        tag_wr = 0; cache_busy = 0;
        @(negedge mclk);
        check_eq({name, "_curloc"}, 32'(tag_cur_loc), 32'(exp_loc));
        tick();
    endtask

    task automatic cpu_write(input logic [31:0] adr);
        logic got_err;
        logic [31:0] d;
        int lat, n_ack, n_req, n_err;
        got_err = 0; d = 32'hFFFF_FFFF; lat = -1; n_ack = 0; n_req = 0; n_err = 0;
        wb_cpu.stb = 1; wb_cpu.adr = adr; wb_cpu.we = 1;
        for (int i = 0; i < 6 && !got_err; i++) begin
            @(negedge mclk);
            if (wb_cpu.ack) n_ack++;
            if (cache_refill_req) n_req++;
            if (wb_cpu.err) begin got_err = 1; lat = i; d = wb_cpu.dat; n_err++; end
        end
        tick();
        wb_cpu.stb = 0; wb_cpu.we = 0;
        repeat (3) begin
            @(negedge mclk);
            if (wb_cpu.ack) n_ack++;
            if (cache_refill_req) n_req++;
            if (wb_cpu.err) n_err++;
        end
        check_eq("wr_err", 32'(got_err), 32'd1);
        check_eq("wr_err_lat", 32'(lat), 32'd1);
        check_eq("wr_err_dat", d, 32'd0);
        check_eq("wr_err_cnt", 32'(n_err), 32'd1);
        check_eq("wr_no_ack", 32'(n_ack), 32'd0);
        check_eq("wr_no_req", 32'(n_req), 32'd0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic seen;
        int stall_evt;

        wb_cpu.stb = 0; wb_cpu.adr = '0; wb_cpu.we = 0;
        refill_dat = '0; refill_ack = 0; cache_busy = 0; cfg_prefill_en = 0;
        tag_wr = 0; tag_uwr = 0; tag_uptr = '0; tag_wdata = '0;

        repeat (3) @(posedge mclk);
        #1;
        check_eq("rst_ack", 32'(wb_cpu.ack), 32'd0);
        check_eq("rst_err", 32'(wb_cpu.err), 32'd0);
        check_eq("rst_dat", wb_cpu.dat, 32'd0);
        check_eq("rst_csb1", 32'(cache_mem_csb1), 32'd1);
        check_eq("rst_addr1", 32'(cache_mem_addr1), 32'd0);
        check_eq("rst_curloc", 32'(tag_cur_loc), 32'd0);
        check_eq("rst_refill_req", 32'(cache_refill_req), 32'd0);
        check_eq("rst_prefill_req", 32'(cache_prefill_req), 32'd0);
        check_eq("rst_refill_adr", refill_adr, 32'd0);
        rst_n = 1;

        // 1: prefill
        count_prefill(n);
        check_eq("prefill_none", 32'(n), 32'd0);
        cfg_prefill_en = 1;
        count_prefill(n);
        check_eq("prefill_once", 32'(n), 32'd1);
        tick();
        cache_busy = 1;
        for (int i = 0; i < 16; i++) begin
            tag_wdata.valid = 1'b1; tag_wdata.tag = 20'(i); tag_wr = 1;
            tick();
            if (i == 4) check_eq("prefill_curloc_mid", 32'(tag_cur_loc), 32'd5);
        end
        tag_wr = 0; cache_busy = 0;
        tick();
        tick();
        check_eq("prefill_curloc_end", 32'(tag_cur_loc), 32'd0);

        // 2: hits
        cpu_hit("hit_104", 32'h0000_0104, 9'h041);
        cpu_hit("hit_7fc", 32'h0000_07FC, 9'h1FF);
        cpu_hit("hit_4a0", 32'h0000_04A0, 9'h128);

        // 3: miss then hit on the refilled line
        cpu_miss("miss_10008", 32'h0001_0008, 4'd1, 32'h1234_5678);
        cpu_hit("hit_10008", 32'h0001_0008, 9'h002);

        // 4: 17 misses wrap the pointer; entry k lands in (1+k)%16
        for (int k = 0; k < 17; k++) begin
            cpu_miss("wrap", (32'h300 + 32'(k)) << 7 | 32'h4, 4'((2 + k) % 16), 32'hA000_0000 + 32'(k));
        end
        cpu_hit("victim_e0", 32'h0001_8780, 9'h000);
        cpu_hit("victim_e1", 32'h0001_8800, 9'h020);

        tag_uptr = 4'd7; tag_wdata.valid = 1'b1; tag_wdata.tag = 20'h003AA; tag_uwr = 1;
        tick();
        tag_uwr = 0;
        check_eq("uwr_curloc", 32'(tag_cur_loc), 32'd2);
        cpu_hit("uwr_hit", 32'h0001_D50C, 9'h0E3);

        tag_uptr = 4'd8; tag_wdata.valid = 1'b1; tag_wdata.tag = 20'h003BB; tag_wr = 1; tag_uwr = 1;
        tick();
        tag_wr = 0; tag_uwr = 0;
        check_eq("wrwin_curloc", 32'(tag_cur_loc), 32'd3);
        cpu_hit("wrwin_e8_kept", 32'h0001_8380, 9'h100);
        cpu_hit("wrwin_e2", 32'h0001_DD80, 9'h040);

        // 5: write attempt
        cpu_write(32'h0001_8780);

        // busy blocks lookup
        cache_busy = 1;
        wb_cpu.stb = 1; wb_cpu.adr = 32'h0001_8780; wb_cpu.we = 0;
        stall_evt = 0;
        repeat (5) begin
            @(negedge mclk);
            if (!cache_mem_csb1 || cache_refill_req || wb_cpu.ack) stall_evt++;
        end
        check_eq("busy_stall", 32'(stall_evt), 32'd0);
        tick();
        wb_cpu.stb = 0; cache_busy = 0;
        tick();

        // 6: reset in the middle of a refill
        wb_cpu.stb = 1; wb_cpu.adr = 32'h0000_0104; wb_cpu.we = 0;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge mclk);
            if (cache_refill_req) seen = 1;
        end
        check_eq("rstmid_req", 32'(seen), 32'd1);
        tick();
        cache_busy = 1;
        tick();
        tick();
        rst_n = 0;
        #1;
        check_eq("rstmid_csb1", 32'(cache_mem_csb1), 32'd1);
        check_eq("rstmid_curloc", 32'(tag_cur_loc), 32'd0);
        check_eq("rstmid_refill_adr", refill_adr, 32'd0);
        check_eq("rstmid_ack", 32'(wb_cpu.ack), 32'd0);
        wb_cpu.stb = 0; cache_busy = 0;
        tick();
        rst_n = 1;
        count_prefill(n);
        check_eq("rstexit_prefill", 32'(n), 32'd1);
        tick();
        cache_busy = 1;
        tick();
        cache_busy = 0;
        tick();
        tick();
        cpu_miss("post_rst", 32'h0000_0104, 4'd1, 32'h5555_AAAA);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
